// File: rtl/conv_sequencer.sv
// conv_sequencer: full-frame scheduler that walks every valid output pixel, fetches its
//   K x K input window over a req/ack read port, then starts the conv engine and waits for it.
// Latency: K*K+2 cycles per pixel minimum (READ window, one CONV cycle, conv_done cycle in WAIT).
// Backpressure: rd_ack=0 stalls READ with all counters held; WAIT holds until conv_done.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   start_operation      begin a frame (only looked at in IDLE)
//   rd_req/rd_addr/rd_ack window read port, one element accepted per rd_req && rd_ack
//   conv_start/conv_done one-cycle start pulse to the conv engine / its completion (WAIT only)
//   out_x, out_y         coordinates of the output pixel being produced
//   busy, done           not-IDLE flag / one-cycle frame-complete pulse
module conv_sequencer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 16,
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_operation,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              conv_start,
  input  logic              conv_done,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CONV,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic [KW-1:0] kx, kx_nxt;
  logic [KW-1:0] ky, ky_nxt;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      kx    <= '0;
      ky    <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      kx    <= kx_nxt;
      ky    <= ky_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    kx_nxt    = kx;
    ky_nxt    = ky;

    unique case (state)
      S_IDLE: begin
        if (start_operation) begin
          x_nxt     = '0;
          y_nxt     = '0;
          kx_nxt    = '0;
          ky_nxt    = '0;
          state_nxt = S_READ;
        end
      end

      S_READ: begin
        // Window is scanned row-major: kx fastest, ky slowest.
        if (rd_ack) begin
          if (kx == K_LAST) begin
            kx_nxt = '0;
            if (ky == K_LAST) begin
              ky_nxt    = '0;
              state_nxt = S_CONV;
            end else begin
              ky_nxt = ky + KW'(1);
            end
          end else begin
            kx_nxt = kx + KW'(1);
          end
        end
      end

      S_CONV: begin
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (conv_done) begin
          if ((x == X_LAST) && (y == Y_LAST)) begin
            state_nxt = S_DONE;
          end else begin
            if (x == X_LAST) begin
              x_nxt = '0;
              y_nxt = y + YW'(1);
            end else begin
              x_nxt = x + XW'(1);
            end
            state_nxt = S_READ;
          end
        end
      end

      S_DONE: begin
        // Leave the coordinates at the origin so IDLE presents rd_addr = 0.
        x_nxt     = '0;
        y_nxt     = '0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Window element address; the 32-bit intermediate is wide enough for any legal
  // image size and the result is truncated to the memory address width.
  assign rd_addr = ADDR_W'((32'(y) + 32'(ky)) * 32'(IMG_W) + 32'(x) + 32'(kx));

  // Moore outputs
  assign rd_req     = (state == S_READ);
  assign conv_start = (state == S_CONV);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_x      = x;
  assign out_y      = y;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: self-checking bench for conv_sequencer.
// Instance a: 5x4 image, K=3. Instance b: 3x3 image, K=3 (single output pixel).
// Inputs are shared except start_operation, which goes only to the selected instance.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_op;
  logic rd_ack;
  logic conv_done;
  logic sel;

  always #5 clk = ~clk;

  // Instance a outputs
  logic        req_a, cs_a, busy_a, done_a;
  logic [15:0] addr_a;
  logic [2:0]  x_a;
  logic [1:0]  y_a;
  // Instance b outputs
  logic        req_b, cs_b, busy_b, done_b;
  logic [15:0] addr_b;
  logic [1:0]  x_b;
  logic [1:0]  y_b;

  conv_sequencer #(.IMG_W(5), .IMG_H(4), .K(3), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .start_operation(start_op && !sel),
    .rd_req(req_a), .rd_addr(addr_a), .rd_ack(rd_ack),
    .conv_start(cs_a), .conv_done(conv_done),
    .out_x(x_a), .out_y(y_a), .busy(busy_a), .done(done_a)
  );

  conv_sequencer #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .start_operation(start_op && sel),
    .rd_req(req_b), .rd_addr(addr_b), .rd_ack(rd_ack),
    .conv_start(cs_b), .conv_done(conv_done),
    .out_x(x_b), .out_y(y_b), .busy(busy_b), .done(done_b)
  );

  // Observed outputs of the selected instance
  logic        o_req, o_cs, o_busy, o_done;
  logic [31:0] o_addr, o_x, o_y;
  assign o_req  = sel ? req_b  : req_a;
  assign o_cs   = sel ? cs_b   : cs_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_addr = sel ? 32'(addr_b) : 32'(addr_a);
  assign o_x    = sel ? 32'(x_b) : 32'(x_a);
  assign o_y    = sel ? 32'(y_b) : 32'(y_a);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic busy_e, input logic req_e,
                             input logic cs_e, input logic done_e,
                             input int x_e, input int y_e, input int addr_e);
    chk({tag, ".busy"}, 32'(o_busy), 32'(busy_e));
    chk({tag, ".rd_req"}, 32'(o_req), 32'(req_e));
    chk({tag, ".conv_start"}, 32'(o_cs), 32'(cs_e));
    chk({tag, ".done"}, 32'(o_done), 32'(done_e));
    chk({tag, ".out_x"}, o_x, 32'(x_e));
    chk({tag, ".out_y"}, o_y, 32'(y_e));
    chk({tag, ".rd_addr"}, o_addr, 32'(addr_e));
  endtask

  // Directed vector: inputs presented before an edge, outputs expected after it.
  typedef struct {
    logic rst_v;
    logic st;
    logic ack;
    logic cd;
    logic e_busy;
    logic e_req;
    logic e_cs;
    logic e_done;
    int   e_x;
    int   e_y;
    int   e_addr;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl[NVEC];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start_op = 1'b0; rd_ack = 1'b0; conv_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference frame: every output pixel in raster order, each window row-major.
  // Runs one frame on the selected instance and compares the accepted read
  // addresses, pixel order, done timing and busy release against it.
  task automatic run_frame(input logic s, input bit rnd_ack, input bit spur, input string tag);
    int w, h, k, ow, oh;
    logic [31:0] exp_addr[$];
    logic [31:0] got_addr[$];
    int exp_px[$];
    int got_px[$];
    int cyc, dones, pend, last_cd, done_cyc;
    bit seen_done, prev_stall, finished, na;
    logic [31:0] prev_addr;

    sel = s;
    if (s) begin w = 3; h = 3; k = 3; end
    else   begin w = 5; h = 4; k = 3; end
    ow = w - k + 1;
    oh = h - k + 1;
    for (int py = 0; py < oh; py++)
      for (int px = 0; px < ow; px++) begin
        exp_px.push_back(py * 256 + px);
        for (int wy = 0; wy < k; wy++)
          for (int wx = 0; wx < k; wx++)
            exp_addr.push_back(32'((py + wy) * w + px + wx));
      end

    cyc = 0; dones = 0; pend = -1; last_cd = -100; done_cyc = -100;
    seen_done = 0; prev_stall = 0; finished = 0; prev_addr = '0;

    @(negedge clk);
    start_op = 1'b1; rd_ack = 1'b0; conv_done = 1'b0;
    while (cyc < 3000 && !finished) begin
      @(negedge clk);
      cyc++;
      start_op  = 1'b0;
      conv_done = 1'b0;
      if (prev_stall && o_req)
        chk({tag, ".addr_stable_on_stall"}, o_addr, prev_addr);
      if (o_cs) begin
        got_px.push_back(int'(o_y) * 256 + int'(o_x));
        pend = 2;
      end
      if (o_done) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1;
          done_cyc  = cyc;
          chk({tag, ".done_after_last_conv_done"}, 32'(cyc), 32'(last_cd + 1));
        end
      end
      if (seen_done && cyc == done_cyc + 1) begin
        chk({tag, ".busy_after_done"}, 32'(o_busy), 32'd0);
        rd_ack = 1'b0;
        finished = 1;
      end else begin
        na = rnd_ack ? ($urandom_range(0, 1) == 1) : 1'b1;
        rd_ack = na;
        if (o_req && na) got_addr.push_back(o_addr);
        prev_stall = o_req && !na;
        prev_addr  = o_addr;
        if (pend > 0) pend--;
        if (pend == 0) begin
          conv_done = 1'b1;
          last_cd   = cyc;
          pend      = -1;
        end
        if (spur) begin
          if (o_busy && $urandom_range(0, 2) == 0) start_op = 1'b1;
          if (o_req && $urandom_range(0, 2) == 0) conv_done = 1'b1;
        end
      end
    end
    start_op = 1'b0; conv_done = 1'b0; rd_ack = 1'b0;

    chk({tag, ".frame_completed"}, 32'(finished), 32'd1);
    chk({tag, ".done_pulses"}, 32'(dones), 32'd1);
    chk({tag, ".read_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      chk({tag, $sformatf(".addr[%0d]", i)}, got_addr[i], exp_addr[i]);
    chk({tag, ".pixel_count"}, 32'(got_px.size()), 32'(exp_px.size()));
    for (int i = 0; i < exp_px.size() && i < got_px.size(); i++)
      chk({tag, $sformatf(".pixel[%0d]", i)}, 32'(got_px[i]), 32'(exp_px[i]));
  endtask

  initial begin
    bit hit;
    int budget;

    rst = 1'b0; start_op = 1'b0; rd_ack = 1'b0; conv_done = 1'b0; sel = 1'b0;

    // Reset held with random inputs: everything stays at reset values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_op  = 1'($urandom_range(0, 1));
      rd_ack    = 1'($urandom_range(0, 1));
      conv_done = 1'($urandom_range(0, 1));
      #1 chk_outputs("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    end

    // Directed table: start, first window with a stall, CONV with a coincident
    // conv_done, WAIT hold, advance to pixel (1,0), ignored mid-frame start.
    //          rst st ack cd  busy req cs dn  x  y  addr
    tbl[0]  = '{0, 1, 1, 1,   0,   0,  0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1,   0,   0,  0, 0,  0, 0, 0};
    tbl[2]  = '{1, 0, 1, 1,   0,   0,  0, 0,  0, 0, 0};
    tbl[3]  = '{1, 0, 1, 1,   0,   0,  0, 0,  0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0,   1,   1,  0, 0,  0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 1};
    tbl[6]  = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 2};
    tbl[7]  = '{1, 0, 0, 0,   1,   1,  0, 0,  0, 0, 2};
    tbl[8]  = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 5};
    tbl[9]  = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 6};
    tbl[10] = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 7};
    tbl[11] = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 10};
    tbl[12] = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 11};
    tbl[13] = '{1, 0, 1, 0,   1,   1,  0, 0,  0, 0, 12};
    tbl[14] = '{1, 0, 1, 0,   1,   0,  1, 0,  0, 0, 0};
    tbl[15] = '{1, 0, 1, 1,   1,   0,  0, 0,  0, 0, 0};
    tbl[16] = '{1, 0, 1, 0,   1,   0,  0, 0,  0, 0, 0};
    tbl[17] = '{1, 0, 0, 1,   1,   1,  0, 0,  1, 0, 1};
    tbl[18] = '{1, 1, 0, 0,   1,   1,  0, 0,  1, 0, 1};
    tbl[19] = '{1, 1, 1, 0,   1,   1,  0, 0,  1, 0, 2};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst = tbl[i].rst_v; start_op = tbl[i].st; rd_ack = tbl[i].ack; conv_done = tbl[i].cd;
      @(posedge clk);
      #1 chk_outputs($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_req, tbl[i].e_cs,
                     tbl[i].e_done, tbl[i].e_x, tbl[i].e_y, tbl[i].e_addr);
    end

    // Release and idle: outputs stay at reset values.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_outputs("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
    end

    run_frame(1'b0, 1'b0, 1'b0, "a_ack1");
    run_frame(1'b0, 1'b1, 1'b0, "a_rndack");
    run_frame(1'b0, 1'b1, 1'b1, "a_spurious");
    run_frame(1'b1, 1'b0, 1'b0, "b_single");
    run_frame(1'b1, 1'b1, 1'b1, "b_rnd");

    // Asynchronous reset during WAIT of pixel (1,0), then restart from origin.
    sel = 1'b0;
    @(negedge clk);
    start_op = 1'b1; rd_ack = 1'b1; conv_done = 1'b0;
    @(negedge clk);
    start_op = 1'b0;
    hit = 0;
    budget = 0;
    while (!hit && budget < 500) begin
      @(negedge clk);
      budget++;
      if (o_cs && o_x == 32'd1 && o_y == 32'd0) hit = 1;
      else if (o_cs) conv_done = 1'b0;
      // Finish pixel (0,0) promptly; withhold conv_done afterwards.
      conv_done = (!o_req && !o_cs && o_busy && o_x == 32'd0) ? 1'b1 : 1'b0;
    end
    chk("midreset.reached_pixel_1_0", 32'(hit), 32'd1);
    conv_done = 1'b0;
    @(negedge clk);
    chk("midreset.in_wait_busy", 32'(o_busy), 32'd1);
    chk("midreset.in_wait_x", o_x, 32'd1);
    #2 rst = 1'b0;
    #1 chk_outputs("midreset.async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; rd_ack = 1'b0;
    @(negedge clk);
    chk_outputs("midreset.idle", 0, 0, 0, 0, 0, 0, 0);
    start_op = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
    chk_outputs("midreset.restart", 1, 1, 0, 0, 0, 0, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the main sequence ever stalls outright.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Top-level scheduler for the convolution datapath. It walks every valid output pixel of an IMG_W x IMG_H image with a K x K kernel. For each pixel it fetches the K*K input window from pixel memory over a req/ack read port, pulses conv_start, and waits for conv_done. It sits between the host start command and the conv engine / pixel memory, and generalises the single-shot IDLE/READ/CONV control into a full-frame loop.

Parameters:
IMG_W, 28, image width in pixels (>= K)
IMG_H, 28, image height in pixels (>= K)
K, 3, kernel side length (>= 1)
ADDR_W, 16, pixel memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start_operation  input  1  begin frame; sampled only in IDLE
rd_req  output  1  window read request, high throughout READ
rd_addr  output  ADDR_W  pixel address of the current window element
rd_ack  input  1  memory accepts one read when rd_req && rd_ack
conv_start  output  1  one-cycle pulse: window loaded, start convolution
conv_done  input  1  conv engine finished current pixel; sampled only in WAIT
out_x  output  $clog2(IMG_W)  column of the current output pixel
out_y  output  $clog2(IMG_H)  row of the current output pixel
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: frame complete

Behaviour:
- Derived values: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1. Internal counters: kx, ky in 0..K-1; x (out_x) in 0..OUT_W-1; y (out_y) in 0..OUT_H-1.
- Reset (rst=0, async): state=IDLE. rd_req=0, conv_start=0, done=0, busy=0, out_x=0, out_y=0, kx=ky=0, rd_addr=0.
- States: IDLE, READ, CONV, WAIT, DONE. Outputs are Moore: rd_req=(state==READ), conv_start=(state==CONV), done=(state==DONE), busy=(state!=IDLE).
- IDLE: if start_operation=1, clear x, y, kx, ky and go to READ. Otherwise hold.
- READ: rd_addr = (y+ky)*IMG_W + (x+kx), computed combinationally from the counters and zero-extended to ADDR_W. On each rd_req&&rd_ack cycle, advance kx. When kx==K-1, set kx=0 and increment ky. When the accepted element is kx==K-1 && ky==K-1, clear kx and ky and go to CONV. With rd_ack=0, all counters hold (stall, no timeout).
- CONV: occupies exactly one cycle, then unconditionally goes to WAIT.
- WAIT: hold until conv_done=1.
  - If x==OUT_W-1 && y==OUT_H-1: go to DONE.
  - Otherwise, if x==OUT_W-1: set x=0 and increment y; else increment x. Then go to READ.
- DONE: occupies one cycle, clears x and y, then goes to IDLE.
- Ignored inputs:
  - start_operation outside IDLE, so no restart mid-frame.
  - rd_ack outside READ.
  - conv_done outside WAIT, including a conv_done coincident with conv_start.
- Window timing: READ lasts at least K*K cycles per pixel. Minimum per-pixel period is K*K+2 cycles (READ + CONV + the conv_done cycle in WAIT).
- Frame start timing: with start_operation sampled high at edge N, rd_req is high from the cycle after edge N.
- Mid-operation reset: all state and outputs return to the reset values immediately (async). No partial-window or partial-frame state is retained.
- Degenerate case K==IMG_W==IMG_H: exactly one output pixel and one window read of K*K elements.

Test Plan:
- Reset: hold rst=0 with random inputs -> rd_req=conv_start=done=busy=0, out_x=out_y=0. Release, idle 5 cycles -> outputs unchanged.
- IMG_W=5, IMG_H=4, K=3, rd_ack=1, conv_done 2 cycles after each conv_start, pulse start_operation:
  - first window rd_addr = 0,1,2,5,6,7,10,11,12;
  - 6 conv_start pulses total, visiting (out_x,out_y) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1);
  - last window = 7,8,9,12,13,14,17,18,19;
  - 54 accepted reads; exactly one done pulse, one cycle after the final conv_done; busy drops with IDLE.
- Same config, rd_ack toggling randomly -> identical address sequence and read count (54). rd_addr stable while rd_ack=0.
- Spurious inputs:
  - start_operation re-asserted mid-frame -> no restart;
  - conv_done pulsed during READ -> ignored;
  - pixel order and read count unchanged.
- rst asserted during the WAIT of pixel (1,0) -> immediate return to reset values. A new start_operation restarts at (0,0) with rd_addr=0.
- K=IMG_W=IMG_H=3 -> 9 reads at addresses 0..8, one conv_start, one done.
